// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with threshold flags, occupancy and one-cycle status pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read mode; standard registered-read otherwise.
module sync_fifo_param #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wr_ack,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_accept_c;
    logic              rd_accept_c;

    assign full         = (count == FULL_CNT);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign wr_accept_c  = wr_en && !full;

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_accept_c) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (wr_accept_c) begin
            wr_ptr <= wr_ptr + AW'(1);
        end
    end

    // Status pulses reflect the request sampled against pre-edge state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_accept_c;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic [CW-1:0] mem_count;
    logic          out_valid;
    logic          fetch_c;

    // Presented word lives in data_out; count spans memory plus that stage.
    assign empty       = !out_valid;
    assign rd_accept_c = rd_en && out_valid;
    assign fetch_c     = (mem_count != '0) && (!out_valid || rd_accept_c);
    assign count       = mem_count + CW'(out_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_count <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            mem_count <= mem_count + CW'(wr_accept_c) - CW'(fetch_c);
            if (fetch_c) begin
                data_out  <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + AW'(1);
                out_valid <= 1'b1;
            end else if (rd_accept_c) begin
                out_valid <= 1'b0;
            end
        end
    end
`else
    assign empty       = (count == '0);
    assign rd_accept_c = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            rd_ptr   <= '0;
            data_out <= '0;
        end else begin
            count <= count + CW'(wr_accept_c) - CW'(rd_accept_c);
            if (rd_accept_c) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed table, corner sequences, random vs queue model.
module tb_sync_fifo_param;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int AF_LVL = 6;
    localparam int AE_LVL = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] data_in;
    logic        rd_en;
    logic [15:0] data_out;
    logic        full, empty, almost_full, almost_empty;
    logic [3:0]  count;
    logic        wr_ack, overflow, underflow;

    sync_fifo_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LVL), .AE_LEVEL(AE_LVL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .wr_ack(wr_ack),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        wr;
        logic [15:0] din;
        logic        rd;
        logic [3:0]  cnt;
        logic        full, empty, af, ae, ack, ovf, unf;
        logic [15:0] dout;
    } vec_t;

    vec_t tbl [20];

    // Reference model: a plain queue plus the last popped word and event pulses.
    logic [15:0] mq[$];
    logic [15:0] m_dout;
    logic        m_ack, m_ovf, m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_ack  = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // One clock: drive request, take the edge, then advance the model.
    task automatic step(input logic w, input logic [15:0] d, input logic r);
        bit m_full, m_empty, wa, ra;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        m_full  = (mq.size() == DEPTH);
        m_empty = (mq.size() == 0);
        wa = w && !m_full;
        ra = r && !m_empty;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (ra) m_dout = mq.pop_front();
        if (wa) mq.push_back(d);
        m_ack = wa;
        m_ovf = w && m_full;
        m_unf = r && m_empty;
    endtask

    task automatic cmp_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".full"},  32'(full),  32'(n == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".af"},    32'(almost_full),  32'(n >= AF_LVL));
        chk({tag, ".ae"},    32'(almost_empty), 32'(n <= AE_LVL));
        chk({tag, ".dout"},  32'(data_out),  32'(m_dout));
        chk({tag, ".ack"},   32'(wr_ack),    32'(m_ack));
        chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
        chk({tag, ".unf"},   32'(underflow), 32'(m_unf));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'd0);
        chk({tag, ".empty"}, 32'(empty), 32'd1);
        chk({tag, ".full"},  32'(full),  32'd0);
        chk({tag, ".af"},    32'(almost_full),  32'd0);
        chk({tag, ".ae"},    32'(almost_empty), 32'd1);
        chk({tag, ".dout"},  32'(data_out), 32'd0);
        chk({tag, ".ack"},   32'(wr_ack),   32'd0);
        chk({tag, ".ovf"},   32'(overflow), 32'd0);
        chk({tag, ".unf"},   32'(underflow), 32'd0);
    endtask

    initial begin
        int k;
        int wr_pct, rd_pct;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifndef SYNC_FIFO_FWFT_EN
        // Directed table: fill, overflow, drain, underflow.
        k = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tbl[k] = '{wr: 1'b1, din: 16'(i + 1), rd: 1'b0, cnt: 4'(i + 1),
                       full: (i + 1 == DEPTH), empty: 1'b0, af: (i + 1 >= AF_LVL),
                       ae: (i + 1 <= AE_LVL), ack: 1'b1, ovf: 1'b0, unf: 1'b0, dout: 16'h0};
            k++;
        end
        tbl[k] = '{wr: 1'b1, din: 16'hBEEF, rd: 1'b0, cnt: 4'd8, full: 1'b1, empty: 1'b0,
                   af: 1'b1, ae: 1'b0, ack: 1'b0, ovf: 1'b1, unf: 1'b0, dout: 16'h0};
        k++;
        tbl[k] = '{wr: 1'b0, din: 16'h0, rd: 1'b0, cnt: 4'd8, full: 1'b1, empty: 1'b0,
                   af: 1'b1, ae: 1'b0, ack: 1'b0, ovf: 1'b0, unf: 1'b0, dout: 16'h0};
        k++;
        for (int i = 0; i < DEPTH; i++) begin
            tbl[k] = '{wr: 1'b0, din: 16'h0, rd: 1'b1, cnt: 4'(DEPTH - 1 - i),
                       full: 1'b0, empty: (DEPTH - 1 - i == 0), af: (DEPTH - 1 - i >= AF_LVL),
                       ae: (DEPTH - 1 - i <= AE_LVL), ack: 1'b0, ovf: 1'b0, unf: 1'b0,
                       dout: 16'(i + 1)};
            k++;
        end
        tbl[k] = '{wr: 1'b0, din: 16'h0, rd: 1'b1, cnt: 4'd0, full: 1'b0, empty: 1'b1,
                   af: 1'b0, ae: 1'b1, ack: 1'b0, ovf: 1'b0, unf: 1'b1, dout: 16'h0008};
        k++;
        tbl[k] = '{wr: 1'b0, din: 16'h0, rd: 1'b0, cnt: 4'd0, full: 1'b0, empty: 1'b1,
                   af: 1'b0, ae: 1'b1, ack: 1'b0, ovf: 1'b0, unf: 1'b0, dout: 16'h0008};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].wr, tbl[i].din, tbl[i].rd);
            chk($sformatf("tbl%0d.count", i), 32'(count),       32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.full", i),  32'(full),        32'(tbl[i].full));
            chk($sformatf("tbl%0d.empty", i), 32'(empty),       32'(tbl[i].empty));
            chk($sformatf("tbl%0d.af", i),    32'(almost_full), 32'(tbl[i].af));
            chk($sformatf("tbl%0d.ae", i),    32'(almost_empty), 32'(tbl[i].ae));
            chk($sformatf("tbl%0d.ack", i),   32'(wr_ack),      32'(tbl[i].ack));
            chk($sformatf("tbl%0d.ovf", i),   32'(overflow),    32'(tbl[i].ovf));
            chk($sformatf("tbl%0d.unf", i),   32'(underflow),   32'(tbl[i].unf));
            chk($sformatf("tbl%0d.dout", i),  32'(data_out),    32'(tbl[i].dout));
        end

        // Simultaneous read/write at count 3 across pointer wrap.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'(16'h0100 + i), 1'b0);
            cmp_model("pre3");
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'(16'h0200 + i), 1'b1);
            cmp_model("both3");
            chk("both3.hold", 32'(count), 32'd3);
        end

        // Both at full: read wins, write rejected.
        while (mq.size() < DEPTH) begin
            step(1'b1, 16'(16'h0300 + mq.size()), 1'b0);
            cmp_model("fill");
        end
        step(1'b1, 16'hCAFE, 1'b1);
        cmp_model("both_full");
        chk("both_full.ovf", 32'(overflow), 32'd1);
        chk("both_full.cnt", 32'(count), 32'd7);

        // Both at empty: write wins, read rejected.
        while (mq.size() > 0) begin
            step(1'b0, 16'h0, 1'b1);
            cmp_model("drain");
        end
        step(1'b1, 16'h5A5A, 1'b1);
        cmp_model("both_empty");
        chk("both_empty.unf", 32'(underflow), 32'd1);
        chk("both_empty.cnt", 32'(count), 32'd1);
        step(1'b0, 16'h0, 1'b1);
        cmp_model("both_empty.rd");
        chk("both_empty.rd_data", 32'(data_out), 32'h5A5A);

        // Asynchronous reset between edges at count 5.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'(16'h0400 + i), 1'b0);
            cmp_model("pre_rst");
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_rst");
        model_reset();
        #2;
        rst_n = 1'b1;
        step(1'b1, 16'h7777, 1'b0);
        cmp_model("post_rst.wr");
        step(1'b0, 16'h0, 1'b1);
        cmp_model("post_rst.rd");
        chk("post_rst.data", 32'(data_out), 32'h7777);

        // Randomised traffic with shifting write/read bias to visit full and empty.
        for (int i = 0; i < 800; i++) begin
            case ((i / 100) % 4)
                0:       begin wr_pct = 80; rd_pct = 30; end
                1:       begin wr_pct = 30; rd_pct = 80; end
                2:       begin wr_pct = 50; rd_pct = 50; end
                default: begin wr_pct = 95; rd_pct = 90; end
            endcase
            step($urandom_range(99) < wr_pct, 16'($urandom), $urandom_range(99) < rd_pct);
            cmp_model($sformatf("rnd%0d", i));
        end
`else
        // First-word-fall-through sequences.
        step(1'b1, 16'h00A5, 1'b0);
        chk("fwft.wr.count", 32'(count), 32'd1);
        chk("fwft.wr.ack",   32'(wr_ack), 32'd1);
        step(1'b0, 16'h0, 1'b0);
        chk("fwft.show.dout",  32'(data_out), 32'h00A5);
        chk("fwft.show.empty", 32'(empty), 32'd0);
        chk("fwft.show.count", 32'(count), 32'd1);
        step(1'b0, 16'h0, 1'b1);
        chk("fwft.rd.empty", 32'(empty), 32'd1);
        chk("fwft.rd.count", 32'(count), 32'd0);
        chk("fwft.rd.unf",   32'(underflow), 32'd0);
        step(1'b0, 16'h0, 1'b1);
        chk("fwft.unf", 32'(underflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 16'(i + 1), 1'b0);
            chk($sformatf("fwft.fill%0d.count", i), 32'(count), 32'(i + 1));
        end
        chk("fwft.full", 32'(full), 32'd1);
        step(1'b1, 16'hBEEF, 1'b0);
        chk("fwft.ovf", 32'(overflow), 32'd1);
        chk("fwft.ovf.count", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("fwft.head%0d", i), 32'(data_out), 32'(i + 1));
            chk($sformatf("fwft.valid%0d", i), 32'(empty), 32'd0);
            step(1'b0, 16'h0, 1'b1);
        end
        chk("fwft.drained.empty", 32'(empty), 32'd1);
        chk("fwft.drained.count", 32'(count), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds, an occupancy output, registered per-cycle status flags and an optional first-word-fall-through (FWFT) read mode. It buffers one data stream between a producer and a consumer in the same clock domain. It defines defined behaviour for simultaneous read/write at every fill level.

## Interface
- `DATA_W`, default 16: data word width in bits, ≥1.
- `DEPTH`, default 8: capacity in words. Must be a power of two, ≥4.
- `AF_LEVEL`, default `DEPTH-2`: `almost_full` asserts when `count >= AF_LEVEL`. Range 1..DEPTH.
- `AE_LEVEL`, default 1: `almost_empty` asserts when `count <= AE_LEVEL`. Range 0..DEPTH-1.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write request.
- `data_in`  in  DATA_W  write data.
- `rd_en`  in  1  read request (pop).
- `data_out`  out  DATA_W  read data.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  no word is available to read.
- `almost_full`  out  1  threshold flag, combinational from `count`.
- `almost_empty`  out  1  threshold flag, combinational from `count`.
- `count`  out  $clog2(DEPTH)+1  number of words held, 0..DEPTH.
- `wr_ack`  out  1  registered; 1 for one cycle after an accepted write.
- `overflow`  out  1  registered; 1 for one cycle after a write was rejected because the FIFO was full.
- `underflow`  out  1  registered; 1 for one cycle after a read was rejected because the FIFO was empty.

## Operation
- A write is accepted when `wr_en && !full`. The word is stored at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- A read is accepted when `rd_en && !empty`. The head word is popped, and `rd_ptr` increments modulo DEPTH.
- Acceptance is evaluated on the state before the clock edge:
  - When full, a write is rejected even if a read is accepted in the same cycle.
  - When empty, a read is rejected even if a write is accepted in the same cycle.
- `count` update at each edge:
  - +1 on write only.
  - −1 on read only.
  - Unchanged when both are accepted or neither is.
  - Never wraps. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Rejected operations leave memory, pointers and `count` unchanged.
- `wr_ack`, `overflow` and `underflow` are recomputed every cycle. Each is 0 in any cycle without the corresponding event.
- Asynchronous reset clears all of the following: pointers, `count`, `data_out`, `wr_ack`, `overflow`, `underflow`, and the FWFT valid stage.
- Reset values after reset: `empty`=1, `almost_empty`=1 (given AE_LEVEL≥0), `full`=0, `almost_full`=0.
- Memory contents are not reset.
- Reset asserted mid-operation discards all stored data immediately, without waiting for a clock edge.

## Timing
- Standard mode:
  - `data_out` is registered. It loads the head word on the edge that accepts a read, so it is valid in the cycle after `rd_en` is sampled.
  - `data_out` holds its value when no read is accepted.
- Write-to-`empty` deassertion: 1 cycle.
- Read-to-`full` deassertion: 1 cycle.
- `wr_ack`, `overflow` and `underflow` rise one cycle after the sampled request and last exactly one cycle per event.
- Back-to-back reads and writes sustain one word per cycle in each direction.

## Configuration
- Macro `SYNC_FIFO_FWFT_EN`.
- Defined (FWFT mode):
  - The head word is presented on `data_out` without a read request.
  - `empty` means `data_out` is invalid.
  - A write into an empty FIFO at edge N gives `data_out` = that word and `empty`=0 after edge N+1.
  - An accepted `rd_en` consumes the presented word. The next word, if any, appears after the same edge.
  - `count` includes the presented word, and total capacity remains DEPTH.
  - `underflow` follows the same rule: `rd_en` while `empty`.
- Undefined: standard mode as described under Timing.

## Test plan
- Reset, then fill: DEPTH=8, DATA_W=16. Write 0x0001..0x0008 on 8 consecutive cycles. Required: `wr_ack`=1 for 8 cycles, `count` steps 1..8, `almost_full` at count 6, `full`=1 after the 8th write.
- Overflow: while full, `wr_en`=1 with 0xBEEF → `overflow`=1 for one cycle, `wr_ack`=0, `count`=8, 0xBEEF never read back.
- Drain and underflow: read 8 times → `data_out` 0x0001..0x0008 in order, `empty`=1. A 9th read → `underflow`=1 for one cycle and `data_out` holds 0x0008.
- Simultaneous access:
  - At count=3, `wr_en`=`rd_en`=1 for 10 cycles → `count` stays 3 and data order is preserved across pointer wrap.
  - At full, both asserted → read accepted, write rejected, `overflow`=1, `count`=7.
  - At empty, both asserted → write accepted, `underflow`=1, `count`=1.
- Mid-operation reset: at count=5, pulse `rst_n` low between clock edges → `count`=0, `empty`=1, `data_out`=0 immediately. The next write/read returns the new word only.
- FWFT (`SYNC_FIFO_FWFT_EN` defined): write 0x00A5 into empty FIFO → `data_out`=0x00A5 and `empty`=0 one cycle later with no `rd_en`. Then one `rd_en` → `empty`=1, `count`=0.
